// File: rtl/seq_scan_ctrl.sv
// Word-to-serial scan controller: valid/ready word intake, MSB-first serialiser,
// programmable overlapping/non-overlapping pattern matcher, detection counter and sticky irq.
module seq_scan_ctrl #(
  parameter int WORD_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [7:0]        cfg_pattern,
  input  logic [3:0]        cfg_len,
  input  logic              cfg_overlap,
  input  logic [CNT_W-1:0]  cfg_thresh,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  output logic              bit_out,
  output logic              bit_valid,
  output logic              det_pulse,
  output logic [CNT_W-1:0]  det_count,
  output logic              irq,
  input  logic              irq_clr,
  output logic              busy
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  localparam int BC_W = $clog2(WORD_W);
  localparam logic [BC_W-1:0] LAST_CNT = BC_W'(WORD_W - 1);

  logic [0:0]        state_r;
  logic [WORD_W-1:0] shifter_r;
  logic [BC_W-1:0]   bitcnt_r;
  logic [7:0]        pattern_r;
  logic [3:0]        len_r;
  logic              overlap_r;
  logic [CNT_W-1:0]  thresh_r;
  logic [6:0]        hist_r;
  logic [3:0]        fill_r;
  logic              det_pulse_r;
  logic [CNT_W-1:0]  count_r;
  logic              irq_r;

  logic              busy_s;
  logic              last_bit_s;
  logic              ready_s;
  logic              bit_s;
  logic              take_s;
  logic              cfg_ok_s;
  logic [7:0]        hist_n_s;
  logic [3:0]        fill_n_s;
  logic              match_s;
  logic              count_inc_s;
  logic [CNT_W-1:0]  count_n_s;
  logic              irq_set_s;

  // Lengths of 0 or above 8 fall back to the full 8-bit pattern.
  function automatic logic [3:0] clamp_len(input logic [3:0] len);
    if ((len == 4'd0) || (len > 4'd8)) begin
      return 4'd8;
    end else begin
      return len;
    end
  endfunction

  function automatic logic [7:0] len_mask(input logic [3:0] len);
    logic [7:0] m;
    m = 8'h00;
    for (int i = 0; i < 8; i++) begin
      m[i] = (i < int'(len));
    end
    return m;
  endfunction

  // Handshake, serial bit and matcher next-state decode.
  always_comb begin
    busy_s      = (state_r == SHIFT);
    last_bit_s  = busy_s && (bitcnt_r == {BC_W{1'b0}});
    ready_s     = !busy_s || last_bit_s;
    bit_s       = busy_s ? shifter_r[WORD_W-1] : 1'b0;
    take_s      = in_valid && ready_s;
    cfg_ok_s    = cfg_we && !busy_s;
    hist_n_s    = {hist_r, bit_s};
    fill_n_s    = (fill_r >= 4'd8) ? 4'd8 : (fill_r + 4'd1);
    match_s     = busy_s && (fill_n_s >= len_r) &&
                  (((hist_n_s ^ pattern_r) & len_mask(len_r)) == 8'h00);
    count_inc_s = match_s && (count_r != {CNT_W{1'b1}});
    count_n_s   = count_r + CNT_W'(1);
    irq_set_s   = count_inc_s && (thresh_r != {CNT_W{1'b0}}) && (count_n_s == thresh_r);
  end

  // Intake FSM and serialiser; a handshake on the last bit reloads for a gapless stream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      shifter_r <= {WORD_W{1'b0}};
      bitcnt_r  <= {BC_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (take_s) begin
            shifter_r <= in_data;
            bitcnt_r  <= LAST_CNT;
            state_r   <= SHIFT;
          end else begin
            state_r   <= IDLE;
          end
        end
        SHIFT: begin
          if (last_bit_s) begin
            if (take_s) begin
              shifter_r <= in_data;
              bitcnt_r  <= LAST_CNT;
            end else begin
              shifter_r <= {WORD_W{1'b0}};
              state_r   <= IDLE;
            end
          end else begin
            shifter_r <= {shifter_r[WORD_W-2:0], 1'b0};
            bitcnt_r  <= bitcnt_r - BC_W'(1);
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Configuration registers, writable only while no word is shifting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pattern_r <= 8'b0001_1011;
      len_r     <= 4'd5;
      overlap_r <= 1'b1;
      thresh_r  <= {CNT_W{1'b0}};
    end else if (cfg_ok_s) begin
      pattern_r <= cfg_pattern;
      len_r     <= clamp_len(cfg_len);
      overlap_r <= cfg_overlap;
      thresh_r  <= cfg_thresh;
    end
  end

  // Matcher history, detection pulse, saturating counter and sticky irq (set beats clear).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_r      <= 7'd0;
      fill_r      <= 4'd0;
      det_pulse_r <= 1'b0;
      count_r     <= {CNT_W{1'b0}};
      irq_r       <= 1'b0;
    end else if (cfg_ok_s) begin
      hist_r      <= 7'd0;
      fill_r      <= 4'd0;
      det_pulse_r <= 1'b0;
      count_r     <= {CNT_W{1'b0}};
      irq_r       <= 1'b0;
    end else begin
      det_pulse_r <= match_s;
      if (busy_s) begin
        if (match_s && !overlap_r) begin
          hist_r <= 7'd0;
          fill_r <= 4'd0;
        end else begin
          hist_r <= hist_n_s[6:0];
          fill_r <= fill_n_s;
        end
      end
      if (count_inc_s) begin
        count_r <= count_n_s;
      end
      if (irq_set_s) begin
        irq_r <= 1'b1;
      end else if (irq_clr) begin
        irq_r <= 1'b0;
      end
    end
  end

  assign in_ready  = ready_s;
  assign busy      = busy_s;
  assign bit_valid = busy_s;
  assign bit_out   = bit_s;
  assign det_pulse = det_pulse_r;
  assign det_count = count_r;
  assign irq       = irq_r;

endmodule
